// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator: pixel/line counters, syncs, strobes, frame count
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic          in_video,
    output logic          hsync,
    output logic          vsync,
    output logic          sol,
    output logic          sof,
    output logic [15:0]   frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam longint CNT_MAX = (longint'(1) << CW) - 1;

    if ((longint'(H_TOTAL - 1) > CNT_MAX) || (longint'(V_TOTAL - 1) > CNT_MAX) ||
        (H_ACTIVE == 0) || (H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
        (V_ACTIVE == 0) || (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_bad_params
        $error("vga_timing_gen: zero timing parameter or totals exceed CW");
    end

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [15:0]   frame_q, frame_d;
    logic          in_video_q, in_video_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;

    // Sync/video flags are decoded from the next-state counters so they land
    // in the same register stage as col/row.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        frame_d = frame_q;
        if (en) begin
            if (col_q == H_LAST) begin
                col_d = '0;
                if (row_q == V_LAST) begin
                    row_d   = '0;
                    frame_d = frame_q + 16'd1;
                end else begin
                    row_d = row_q + CW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        in_video_d = (col_d < H_ACT) && (row_d < V_ACT);
        hsync_d    = ((col_d >= HS_FIRST) && (col_d <= HS_LAST)) ? H_POL : ~H_POL;
        vsync_d    = ((row_d >= VS_FIRST) && (row_d <= VS_LAST)) ? V_POL : ~V_POL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            frame_q    <= '0;
            in_video_q <= 1'b1;
            hsync_q    <= ~H_POL;
            vsync_q    <= ~V_POL;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            frame_q    <= frame_d;
            in_video_q <= in_video_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
        end
    end

    assign col       = col_q;
    assign row       = row_q;
    assign frame_cnt = frame_q;
    assign in_video  = in_video_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign sol       = en && (col_q == '0);
    assign sof       = sol && (row_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    localparam int HA = 40, HF = 4, HS = 8, HB = 6;
    localparam int VA = 30, VF = 3, VS = 2, VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

    logic [7:0]  col, row;
    logic        iv, hs, vs, sol, sof;
    logic [15:0] fc;
    logic [11:0] dcol, drow;
    logic        div, dhs, dvs, dsol, dsof;
    logic [15:0] dfc;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b1), .V_POL(1'b0), .CW(8)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .col(col), .row(row), .in_video(iv),
        .hsync(hs), .vsync(vs), .sol(sol), .sof(sof), .frame_cnt(fc)
    );

    vga_timing_gen dut_def (
        .clk(clk), .rst(rst), .en(en), .col(dcol), .row(drow), .in_video(div),
        .hsync(dhs), .vsync(dvs), .sol(dsol), .sof(dsof), .frame_cnt(dfc)
    );

    int checks = 0;
    int passed = 0;
    int m_col, m_row, m_frame;

    // Reference raster position as a linear pixel index within the frame.
    task automatic advance_model();
        int p;
        p = m_row * HT + m_col + 1;
        if (p == FRAME) begin
            p = 0;
            m_frame = (m_frame + 1) & 16'hFFFF;
        end
        m_col = p % HT;
        m_row = p / HT;
    endtask

    task automatic reset_model();
        m_col = 0;
        m_row = 0;
        m_frame = 0;
    endtask

    // Small instance: H_POL=1 (hsync high in pulse), V_POL=0 (vsync low in pulse).
    function automatic logic [34:0] exp_vec();
        logic e_iv, e_hs, e_vs;
        e_iv = (m_col < HA) && (m_row < VA);
        e_hs = (m_col >= HA + HF) && (m_col < HA + HF + HS);
        e_vs = !((m_row >= VA + VF) && (m_row < VA + VF + VS));
        return {8'(m_col), 8'(m_row), 16'(m_frame), e_iv, e_hs, e_vs};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        reset_model();
        #3;
        checks++;
        if ({col, row, fc, iv, hs, vs} !== exp_vec())
            $display("FAIL reset_small: got %h expected %h", {col, row, fc, iv, hs, vs}, exp_vec());
        else passed++;
        checks++;
        if ({dcol, drow, dfc, div, dhs, dvs} !== {12'd0, 12'd0, 16'd0, 3'b111})
            $display("FAIL reset_default: got %h expected %h", {dcol, drow, dfc, div, dhs, dvs},
                     {12'd0, 12'd0, 16'd0, 3'b111});
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_first_step();
        en = 1'b1;
        #1;
        checks++;
        if ({sol, sof, dsol, dsof} !== 4'b1111)
            $display("FAIL first_sof: got %b expected 1111", {sol, sof, dsol, dsof});
        else passed++;
        @(posedge clk);
        advance_model();
        #1;
        checks++;
        if ({col, dcol} !== {8'd1, 12'd1})
            $display("FAIL first_step_col: got %0d/%0d expected 1/1", col, dcol);
        else passed++;
        en = 1'b0;
    endtask

    task automatic test_default_line();
        int low;
        low = 0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        reset_model();
        for (int i = 0; i < 800; i++) begin
            en = 1'b1;
            #1;
            checks++;
            if ({dcol, dhs, div, dsol} !== {12'(i), !(i >= 656 && i <= 751), i < 640, i == 0})
                $display("FAIL default_line col %0d: got %h expected %h", i, {dcol, dhs, div, dsol},
                         {12'(i), !(i >= 656 && i <= 751), i < 640, i == 0});
            else passed++;
            if (!dhs) low++;
            @(posedge clk);
            advance_model();
            #1;
        end
        checks++;
        if ({dcol, drow, dvs} !== {12'd0, 12'd1, 1'b1})
            $display("FAIL default_line_wrap: got col %0d row %0d vs %b expected 0 1 1", dcol, drow, dvs);
        else passed++;
        checks++;
        if (low !== 96) $display("FAIL default_hsync_width: got %0d expected 96", low);
        else passed++;
    endtask

    task automatic test_full_frames();
        int last_sof, last_sol, iv_cnt, hs_cnt;
        last_sof = -1;
        last_sol = -1;
        iv_cnt = 0;
        hs_cnt = 0;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            en = 1'b1;
            #1;
            checks++;
            if ({sol, sof} !== {m_col == 0, m_col == 0 && m_row == 0})
                $display("FAIL frames_strobe: got %b expected %b", {sol, sof},
                         {m_col == 0, m_col == 0 && m_row == 0});
            else passed++;
            if (sof) begin
                if (last_sof >= 0) begin
                    checks++;
                    if ({32'(i - last_sof), 32'(iv_cnt)} !== {32'(FRAME), 32'(HA * VA)})
                        $display("FAIL frame_len_video: got %0d/%0d expected %0d/%0d",
                                 i - last_sof, iv_cnt, FRAME, HA * VA);
                    else passed++;
                end
                last_sof = i;
                iv_cnt = 0;
            end
            if (sol) begin
                if (last_sol >= 0) begin
                    checks++;
                    if ({32'(i - last_sol), 32'(hs_cnt)} !== {32'(HT), 32'(HS)})
                        $display("FAIL line_len_hsync: got %0d/%0d expected %0d/%0d",
                                 i - last_sol, hs_cnt, HT, HS);
                    else passed++;
                end
                last_sol = i;
                hs_cnt = 0;
            end
            if (iv) iv_cnt++;
            if (hs) hs_cnt++;
            @(posedge clk);
            advance_model();
            #1;
            checks++;
            if ({col, row, fc, iv, hs, vs} !== exp_vec())
                $display("FAIL frames_state: got %h expected %h", {col, row, fc, iv, hs, vs}, exp_vec());
            else passed++;
        end
    endtask

    task automatic test_random_en();
        logic e;
        for (int i = 0; i < 3000; i++) begin
            e = 1'($urandom_range(0, 1));
            en = e;
            #1;
            checks++;
            if ({sol, sof} !== {e && m_col == 0, e && m_col == 0 && m_row == 0})
                $display("FAIL random_strobe: got %b expected %b", {sol, sof},
                         {e && m_col == 0, e && m_col == 0 && m_row == 0});
            else passed++;
            @(posedge clk);
            if (e) advance_model();
            #1;
            checks++;
            if ({col, row, fc, iv, hs, vs} !== exp_vec())
                $display("FAIL random_state: got %h expected %h", {col, row, fc, iv, hs, vs}, exp_vec());
            else passed++;
        end
    endtask

    task automatic run_to(input int c, input int r, input string name);
        int n;
        n = 0;
        while (!(m_col == c && m_row == r) && n < 2 * FRAME) begin
            en = 1'b1;
            @(posedge clk);
            advance_model();
            #1;
            n++;
        end
        checks++;
        if ({col, row} !== {8'(c), 8'(r)})
            $display("FAIL %s_reach: got (%0d,%0d) expected (%0d,%0d)", name, col, row, c, r);
        else passed++;
    endtask

    task automatic test_en_pause();
        logic [34:0] held;
        run_to(HT - 1, VT - 1, "pause");
        held = exp_vec();
        for (int k = 0; k < 2; k++) begin
            en = 1'b0;
            #1;
            checks++;
            if ({sol, sof} !== 2'b00) $display("FAIL pause_strobe: got %b expected 00", {sol, sof});
            else passed++;
            @(posedge clk);
            #1;
            checks++;
            if ({col, row, fc, iv, hs, vs} !== held)
                $display("FAIL pause_hold: got %h expected %h", {col, row, fc, iv, hs, vs}, held);
            else passed++;
        end
        en = 1'b1;
        @(posedge clk);
        advance_model();
        #1;
        checks++;
        if ({col, row, fc, iv, hs, vs} !== exp_vec() || m_row != 0 || m_col != 0)
            $display("FAIL pause_resume: got %h expected %h", {col, row, fc, iv, hs, vs}, exp_vec());
        else passed++;
        checks++;
        if ({sol, sof} !== 2'b11) $display("FAIL pause_sof: got %b expected 11", {sol, sof});
        else passed++;
    endtask

    task automatic test_async_reset();
        run_to(30, 20, "areset");
        en = 1'b0;
        #2;
        rst = 1'b1;
        reset_model();
        #1;
        checks++;
        if ({col, row, fc, iv, hs, vs} !== exp_vec())
            $display("FAIL areset_small: got %h expected %h", {col, row, fc, iv, hs, vs}, exp_vec());
        else passed++;
        checks++;
        if ({dcol, drow, dfc, div, dhs, dvs} !== {12'd0, 12'd0, 16'd0, 3'b111})
            $display("FAIL areset_default: got %h expected %h", {dcol, drow, dfc, div, dhs, dvs},
                     {12'd0, 12'd0, 16'd0, 3'b111});
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        en = 1'b1;
        #1;
        checks++;
        if ({sol, sof} !== 2'b11) $display("FAIL areset_sof: got %b expected 11", {sol, sof});
        else passed++;
        @(posedge clk);
        advance_model();
        #1;
        checks++;
        if ({col, row, fc} !== {8'd1, 8'd0, 16'd0})
            $display("FAIL areset_step: got %h expected %h", {col, row, fc}, {8'd1, 8'd0, 16'd0});
        else passed++;
    endtask

    task automatic test_frame_wrap();
        en = 1'b0;
        force dut.frame_q = 16'hFFFF;
        #1;
        release dut.frame_q;
        m_frame = 16'hFFFF;
        #1;
        checks++;
        if (fc !== 16'hFFFF) $display("FAIL wrap_preset: got %h expected ffff", fc);
        else passed++;
        run_to(HT - 1, VT - 1, "wrap");
        en = 1'b1;
        @(posedge clk);
        advance_model();
        #1;
        checks++;
        if ({col, row, fc} !== {8'd0, 8'd0, 16'h0000} || m_frame != 0)
            $display("FAIL wrap_frame_cnt: got %h expected %h", {col, row, fc}, {8'd0, 8'd0, 16'h0000});
        else passed++;
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_default_line();
        test_full_frames();
        test_random_en();
        test_en_pause();
        test_async_reset();
        test_frame_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
